seq_divider_8by4: RTL
=====================

SEQ_DIVIDER_8BY4 -- requirements
Module: seq_divider_8by4

Interface
REQ-001 Parameters: none; widths fixed at 8-bit dividend, 4-bit divisor.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned numerator; captured on accepted start.
REQ-006 divisor  input  4  unsigned denominator; captured on accepted start.
REQ-007 busy  output  1  high in CALC and DONE states.
REQ-008 done  output  1  one-cycle pulse; results valid in that cycle and after.
REQ-009 quotient  output  8  unsigned floor(dividend/divisor).
REQ-010 remainder  output  4  unsigned dividend mod divisor.
REQ-011 div_by_zero  output  1  high with results when the captured divisor was 0.

Function
REQ-012 FSM states: IDLE, CALC, DONE; no other reachable state.
REQ-013 IDLE -> CALC on start=1 with nonzero divisor; latch operands, clear partial remainder, load bit counter with 7.
REQ-014 IDLE -> DONE on start=1 with divisor=0; quotient=8'hFF, remainder=4'h0, div_by_zero=1.
REQ-015 CALC: restoring division, one quotient bit per cycle, MSB first; 5-bit partial remainder P.
REQ-016 Each CALC cycle: T = {P[3:0], next dividend bit}; if T >= {1'b0,divisor}, P = T - divisor and quotient bit = 1, else P = T and quotient bit = 0.
REQ-017 CALC lasts exactly 8 cycles; on the cycle the counter reaches 0, transition to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-019 Latency: start sampled at edge N; done high in the cycle after edge N+9 (nonzero divisor) or after edge N+1 (zero divisor).
REQ-020 quotient, remainder, div_by_zero registered; they hold their values from DONE until the next accepted start.
REQ-021 div_by_zero cleared on every accepted start with nonzero divisor.
REQ-022 start while busy=1 ignored; operand changes while busy do not affect the running result.
REQ-023 start held high continuously: a new operation is accepted in the first IDLE cycle after DONE, giving back-to-back operation every 10 cycles.
REQ-024 Arithmetic invariant for nonzero divisor: quotient*divisor + remainder == dividend, remainder < divisor.

Reset
REQ-025 rst_n=0 at a rising edge forces IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter and P cleared.
REQ-026 Reset mid-CALC or in DONE aborts the operation; no done pulse is produced for it.
REQ-027 start is ignored in any cycle where rst_n=0.

Structure
REQ-028 Shared package div_pkg holds the state enum typedef and the width constants (dividend 8, divisor 4, iteration count 8).
REQ-029 One sub-module, div_step: combinational single restoring step (inputs partial remainder, incoming bit, divisor; outputs new remainder, quotient bit), instantiated once.
REQ-030 Implementation is a single always_ff for state/datapath plus combinational next-state logic; no latches, no multicycle paths.

Verification
REQ-031 200 / 7 -> done after 9 cycles, quotient=28, remainder=4, div_by_zero=0.
REQ-032 255 / 15 -> quotient=17, remainder=0; 5 / 9 -> quotient=0, remainder=5.
REQ-033 42 / 0 -> done on the next cycle, quotient=8'hFF, remainder=0, div_by_zero=1; a following 42/6 gives quotient=7, remainder=0, div_by_zero=0.
REQ-034 Start 100/3, pulse start with 9/1 at CALC cycle 3 -> ignored; result quotient=33, remainder=1.
REQ-035 Start 100/3, rst_n=0 at CALC cycle 4 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-036 Exhaustive sweep of all 256x16 operand pairs -> REQ-024 holds for every nonzero divisor, REQ-014 holds for divisor 0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the 8-by-4 sequential divider.
// No timing of its own; pure declarations.
// No flow control; consumed by the divider top and its step cell.
package div_pkg;
    localparam int DVD_W = 8;               // dividend / quotient width
    localparam int DVS_W = 4;               // divisor / remainder width
    localparam int ITERS = 8;               // one quotient bit per iteration
    localparam int CNT_W = $clog2(ITERS);   // bit counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
// Purely combinational, zero cycles.
// No flow control; evaluated every cycle, used only while calculating.
module div_step
    import div_pkg::*;
(
    input  logic [DVS_W:0]   p_in,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   p_out,
    output logic             q_bit
);
    logic [DVS_W:0] t;
    logic [DVS_W:0] diff;
    // The partial remainder always stays below the divisor, so its MSB is zero
    // going in and only the low bits take part in the shift.
    logic           unused_p_msb;

    assign unused_p_msb = p_in[DVS_W];

    // Trial subtraction; keep the difference only if it did not go negative.
    always_comb begin
        t     = {p_in[DVS_W-1:0], bit_in};
        diff  = t - {1'b0, divisor};
        q_bit = (t >= {1'b0, divisor});
        p_out = q_bit ? diff : t;
    end
endmodule

// File: rtl/seq_divider_8by4.sv
// Unsigned 8-bit by 4-bit restoring divider, one quotient bit per cycle.
// Latency: done pulses 9 cycles after an accepted start (1 cycle for divide-by-zero).
// start is accepted only in IDLE; requests while busy are dropped, not queued.
module seq_divider_8by4
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVS_W:0]     p_q, p_d;
    logic [DVD_W-1:0]   dvd_q, dvd_d;       // dividend, shifted out MSB first
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic [DVD_W-1:0]   qacc_q, qacc_d;     // quotient bits collected so far
    logic [DVD_W-1:0]   quot_q, quot_d;
    logic [DVS_W-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DVS_W:0]     step_p;
    logic               step_q;

    div_step u_step (
        .p_in    (p_q),
        .bit_in  (dvd_q[DVD_W-1]),
        .divisor (dvs_q),
        .p_out   (step_p),
        .q_bit   (step_q)
    );

    // Next-state and datapath: capture on start, iterate in CALC, publish on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qacc_d  = qacc_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    p_d    = '0;
                    qacc_d = '0;
                    cnt_d  = CNT_W'(ITERS - 1);
                    if (divisor == '0) begin
                        // Nothing to iterate; report saturated quotient right away.
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        dbz_d   = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                p_d    = step_p;
                dvd_d  = {dvd_q[DVD_W-2:0], 1'b0};
                qacc_d = {qacc_q[DVD_W-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    quot_d  = {qacc_q[DVD_W-2:0], step_q};
                    rem_d   = step_p[DVS_W-1:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // done trails the DONE state by one cycle, so it lands in the first IDLE cycle.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    // All state and registered outputs; synchronous active-low reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qacc_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qacc_q  <= qacc_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
